prescaler: RTL and testbench

- Programmable clock prescaler. It derives a slow serial clock (o_sclk) from the system clock, with a 50% duty cycle.
- It also produces single-cycle rise and fall strobes that downstream logic in the counter design uses as clock enables.
- The divide ratio is loaded at run time through an 8-bit load port.

---
 rtl/prescaler_pkg.sv | 23 ++
 rtl/prescaler_edge_gen.sv | 35 +++
 rtl/prescaler.sv | 79 +++++++
 tb/tb_prescaler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prescaler_pkg.sv
// Shared constants, operation decode and types for the programmable sclk prescaler.
package prescaler_pkg;

    localparam int PRESC_DW        = 8;
    localparam int PRESC_RST_SCALE = 0;

    // What the divider does on a given sysclk edge; load outranks counting.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_COUNT = 2'd2
    } presc_op_e;

    function automatic presc_op_e presc_decode_op(input logic ld, input logic en);
        if (ld) begin
            return OP_LOAD;
        end else if (en) begin
            return OP_COUNT;
        end
        return OP_IDLE;
    endfunction

endpackage

// File: rtl/prescaler_edge_gen.sv
// Registered rise/fall strobes, one sysclk cycle wide, aligned with the first
// cycle in which the divided clock shows its new level.
module prescaler_edge_gen (
    input  logic i_sysclk,
    input  logic i_sysrst,
    input  logic i_toggle,
    input  logic i_sclk,
    output logic o_rise,
    output logic o_fall
);

    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // A toggle from low produces a rise, from high a fall; never both.
    always_comb begin
        rise_d = i_toggle & ~i_sclk;
        fall_d = i_toggle &  i_sclk;
    end

    // Strobe registers, cleared immediately by reset.
    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/prescaler.sv
// Programmable prescaler: o_sclk half period is scale+1 sysclk cycles, with
// registered single-cycle rise/fall strobes for use as clock enables.
module prescaler
    import prescaler_pkg::*;
#(
    parameter int DW = PRESC_DW
) (
    input  logic          i_sysclk,
    input  logic          i_sysrst,
    input  logic          i_module_en,
    input  logic          i_ld,
    input  logic [DW-1:0] i_ld_data,
    output logic          o_sclk,
    output logic          o_sclk_rise,
    output logic          o_sclk_fall
);

    logic [DW-1:0] scale_q, scale_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;
    logic          toggle;
    presc_op_e     op;

    // Classify the current edge: load, count or hold.
    always_comb begin
        op = presc_decode_op(i_ld, i_module_en);
    end

    // Equality compare means cnt never passes scale, so scale=255 is safe and a
    // load (the only way scale changes) always restarts cnt from zero.
    always_comb begin
        scale_d = scale_q;
        cnt_d   = cnt_q;
        sclk_d  = sclk_q;
        toggle  = 1'b0;
        unique case (op)
            OP_LOAD: begin
                scale_d = i_ld_data;
                cnt_d   = '0;
            end
            OP_COUNT: begin
                if (cnt_q == scale_q) begin
                    cnt_d  = '0;
                    sclk_d = ~sclk_q;
                    toggle = 1'b1;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Divider state; reset also discards the loaded ratio.
    always_ff @(posedge i_sysclk or posedge i_sysrst) begin
        if (i_sysrst) begin
            scale_q <= DW'(PRESC_RST_SCALE);
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
        end else begin
            scale_q <= scale_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
        end
    end

    prescaler_edge_gen u_edge_gen (
        .i_sysclk (i_sysclk),
        .i_sysrst (i_sysrst),
        .i_toggle (toggle),
        .i_sclk   (sclk_q),
        .o_rise   (o_sclk_rise),
        .o_fall   (o_sclk_fall)
    );

    assign o_sclk = sclk_q;

endmodule

// File: tb/tb_prescaler.sv
// Randomised and directed bench for the prescaler with a per-cycle scoreboard.
module tb_prescaler;

    logic       clk = 1'b0;
    logic       rst;
    logic       en = 1'b0;
    logic       ld = 1'b0;
    logic [7:0] ld_data = 8'd0;
    logic       o_sclk, o_sclk_rise, o_sclk_fall;

    typedef struct packed {
        logic sclk;
        logic rise;
        logic fall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: half period = N+1 enabled cycles since last toggle or load.
    int   m_n = 0;
    int   m_elapsed = 0;
    logic m_sclk = 1'b0;

    always #5 clk = ~clk;

    prescaler #(.DW(8)) dut (
        .i_sysclk    (clk),
        .i_sysrst    (rst),
        .i_module_en (en),
        .i_ld        (ld),
        .i_ld_data   (ld_data),
        .o_sclk      (o_sclk),
        .o_sclk_rise (o_sclk_rise),
        .o_sclk_fall (o_sclk_fall)
    );

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, want, $time);
        end
    endtask

    // One sysclk edge: advance the model with the inputs present at the edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        e = '0;
        if (rst) begin
            m_n = 0;
            m_elapsed = 0;
            m_sclk = 1'b0;
        end else if (ld) begin
            m_n = int'(ld_data);
            m_elapsed = 0;
        end else if (en) begin
            m_elapsed++;
            if (m_elapsed == m_n + 1) begin
                m_sclk = ~m_sclk;
                m_elapsed = 0;
                e.rise = m_sclk;
                e.fall = ~m_sclk;
            end
        end
        e.sclk = m_sclk;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: compare every presented output cycle with the scoreboard head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({o_sclk, o_sclk_rise, o_sclk_fall} !== e) begin
                errors++;
                $display("FAIL scoreboard t=%0t got sclk/rise/fall=%b%b%b expected %b%b%b",
                         $time, o_sclk, o_sclk_rise, o_sclk_fall, e.sclk, e.rise, e.fall);
            end
        end
    end

    task automatic wait_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (o_sclk_rise) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_rise: got no rise expected one within 600 cycles");
    endtask

    task automatic count_to_toggle(input string name, input int want);
        int t;
        t = 0;
        while (t < 600) begin
            step();
            t++;
            if (o_sclk_rise || o_sclk_fall) break;
        end
        chk(name, t, want);
    endtask

    // Measure high and low lengths of the next full o_sclk period.
    task automatic measure(input string name, input int want_hi, input int want_lo);
        bit ok;
        int hi, lo;
        wait_rise(ok);
        if (!ok) return;
        hi = 1;
        while (hi < 600) begin
            step();
            if (!o_sclk) break;
            hi++;
        end
        lo = 1;
        while (lo < 600) begin
            step();
            if (o_sclk) break;
            lo++;
        end
        chk({name, "_high"}, hi, want_hi);
        chk({name, "_low"}, lo, want_lo);
    endtask

    initial begin : stim
        bit   ok;
        int   hi;
        logic s;

        rst = 1'b0;
        #1 rst = 1'b1;

        // Reset held for 60 ns with enable low.
        repeat (6) step();
        chk("reset_sclk", o_sclk, 0);
        chk("reset_rise", o_sclk_rise, 0);
        chk("reset_fall", o_sclk_fall, 0);

        // Default ratio N=0 after release.
        rst = 1'b0;
        repeat (2) step();
        en = 1'b1;
        measure("n0", 1, 1);

        // Load 7 while enabled.
        ld_data = 8'd7;
        ld = 1'b1;
        step();
        ld = 1'b0;
        count_to_toggle("n7_first_toggle", 8);
        measure("n7", 8, 8);

        // Enable gating mid high half-period; we are in the rise cycle.
        hi = 1;
        repeat (2) begin
            step();
            hi += int'(o_sclk);
        end
        en = 1'b0;
        repeat (5) begin
            step();
            hi += int'(o_sclk);
        end
        en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (!o_sclk) break;
            hi++;
        end
        chk("stall_high_time", hi, 13);

        // Load while disabled, then enable.
        en = 1'b0;
        ld_data = 8'd3;
        ld = 1'b1;
        step();
        ld = 1'b0;
        en = 1'b1;
        measure("n3_dis_load", 4, 4);

        // Load coinciding with terminal count.
        for (int i = 0; i < 50; i++) begin
            if (m_elapsed == m_n) break;
            step();
        end
        s = o_sclk;
        ld_data = 8'd3;
        ld = 1'b1;
        step();
        ld = 1'b0;
        chk("tc_load_rise", o_sclk_rise, 0);
        chk("tc_load_fall", o_sclk_fall, 0);
        chk("tc_load_sclk_held", o_sclk, s);
        count_to_toggle("tc_load_next_toggle", 4);

        // Largest ratio: half period 256.
        ld_data = 8'd255;
        ld = 1'b1;
        step();
        ld = 1'b0;
        count_to_toggle("n255_first_toggle", 256);

        // Randomised traffic.
        repeat (400) begin
            ld = ($urandom_range(0, 19) == 0);
            ld_data = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 9));
            en = ($urandom_range(0, 3) != 0);
            step();
        end

        // Async reset while o_sclk is high.
        ld = 1'b1;
        ld_data = 8'd3;
        en = 1'b1;
        step();
        ld = 1'b0;
        wait_rise(ok);
        step();
        chk("pre_reset_sclk", o_sclk, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_sclk", o_sclk, 0);
        chk("async_reset_rise", o_sclk_rise, 0);
        chk("async_reset_fall", o_sclk_fall, 0);
        @(negedge clk);
        repeat (2) step();
        rst = 1'b0;
        measure("post_reset_n0", 1, 1);

        en = 1'b0;
        step();
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
